// File: rtl/alib_stream_fifo_pkg.sv
// Shared types and constants for the ALFA stream FIFO.
// Read-mode constants, pointer/level width helpers, handshake op decode.
package alib_stream_fifo_pkg;

  localparam bit MODE_FWFT = 1'b1;
  localparam bit MODE_REG  = 1'b0;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic fifo_op_e fifo_op(
    input logic push,
    input logic pop
  );
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/alib_fifo_ptr.sv
// Wrapping index counter 0..DEPTH-1, safe for any DEPTH >= 2.
// Ports: clk, rst, clr (sync clear), inc (advance), ptr (registered index).
module alib_fifo_ptr
  import alib_stream_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/alib_stream_fifo.sv
// Circular stream FIFO with valid/ready on both sides, FWFT or registered read.
// Ports: clk, rst, flush; in_* write side; out_* read side; level, almost_full/empty flags.
module alib_stream_fifo
  import alib_stream_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter bit FWFT      = 1'b1,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int PW = ptr_w(DEPTH),
  localparam int LW = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    level,
  output logic             almost_full,
  output logic             almost_empty
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("alib_stream_fifo: DEPTH must be >= 2");
  end
  if (AF_THRESH > DEPTH) begin : g_bad_af
    $error("alib_stream_fifo: AF_THRESH must be <= DEPTH");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("alib_stream_fifo: AE_THRESH must be < DEPTH");
  end

  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L = LW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             has_data;
  logic             push;
  logic             pop;
  logic             kill;
  fifo_op_e         op;

  // rst/flush win over any handshake in the same cycle
  assign kill     = rst | flush;
  assign in_ready = (level != FULL);
  assign has_data = (level != '0);
  assign push     = in_valid & in_ready;
  assign pop      = out_ready & has_data;
  assign op       = fifo_op(push, pop);

  alib_fifo_ptr #(.DEPTH(DEPTH)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (head)
  );

  alib_fifo_ptr #(.DEPTH(DEPTH)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (tail)
  );

  always_ff @(posedge clk) begin
    if (push && !kill) begin
      mem[head] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      level <= '0;
    end else begin
      unique case (op)
        OP_PUSH: level <= level + 1'b1;
        OP_POP:  level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  if (FWFT == MODE_FWFT) begin : g_fwft
    assign out_valid = has_data;
    assign out_data  = mem[tail];
  end else begin : g_reg
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;

    // flush drops the pending pulse but keeps the last word visible
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else if (flush) begin
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= pop;
        if (pop) begin
          rd_data <= mem[tail];
        end
      end
    end

    assign out_valid = rd_valid;
    assign out_data  = rd_data;
  end

endmodule
